register_write_arbiter: RTL and testbench
=========================================

// Module: register_write_arbiter
// PURPOSE
//   Shares the single write port of register_block (write_id/write_value) among
//   N_REQ writeback requesters (ALU result, memory load, PC incrementer, stack unit).
//   Round-robin grant, valid/ready handshake, optional lock for multi-register
//   sequences (e.g. SP then PC on call). Registered output feeds register_block.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   ID_W     4   register id width
//   DATA_W   8   register data width
// PORTS
//   clock       in   1              system clock; all state on posedge
//   reset_n     in   1              asynchronous, active-low reset
//   req_valid   in   N_REQ          requester i has a write pending
//   req_ready   out  N_REQ          requester i's write accepted this cycle
//   req_id      in   N_REQ*ID_W     target id of requester i, slice [i*ID_W +: ID_W]
//   req_value   in   N_REQ*DATA_W   write data of requester i, slice [i*DATA_W +: DATA_W]
//   req_lock    in   N_REQ          keep the grant after this transfer
//   wr_en       out  1              a valid write is presented this cycle
//   wr_id       out  ID_W           to register_block write_id
//   wr_value    out  DATA_W         to register_block write_value
//   err_bad_id  out  1              one-cycle pulse: an accepted id was >= NUM_REGS
//   grant_idx   out  $clog2(N_REQ)  index of the last accepted requester
// BEHAVIOUR
//   - Reset (async, reset_n=0): wr_en=0, wr_id=REG_DISCARD (4'hF), wr_value=0,
//     err_bad_id=0, grant_idx=0, lock cleared, rr pointer = N_REQ-1 (requester 0 wins
//     first). req_ready=0 while reset_n=0.
//   - Grant: combinational in the same cycle. At most one req_ready bit is high, and
//     only for a requester with req_valid=1. Transfer = valid & ready.
//   - Round-robin: search starts at rr_ptr+1 mod N_REQ. rr_ptr updates to the
//     winner on every transfer only; idle cycles leave rr_ptr unchanged.
//   - Latency: accepted in cycle N -> wr_en=1, wr_id, wr_value presented in cycle N+1.
//     register_block captures it at the end of N+1. Full throughput: one write per cycle.
//   - No transfer in cycle N -> cycle N+1: wr_en=0, wr_id=REG_DISCARD, wr_value=0.
//   - Lock: a transfer with req_lock=1 sets locked=1 and owner=winner. While locked,
//     only owner is eligible and all other ready bits are 0. Lock releases on an owner
//     transfer with req_lock=0, or on any cycle where owner drops req_valid. Release
//     takes effect the next cycle. rr_ptr = owner after release.
//   - Bad id (req_id >= NUM_REGS, i.e. 0xD..0xF): transfer still completes (ready=1).
//     Cycle N+1: wr_en=0, wr_id=REG_DISCARD, err_bad_id=1 for exactly one cycle.
//     Lock semantics still apply.
//   - Same id on consecutive cycles: both writes are presented in order; the last wins.
//   - Reset mid-operation: an accepted write not yet presented is dropped, and wr_en
//     falls immediately. No partial lock state survives reset.
//   - Inputs are sampled only on transfer cycles. A requester may change id/value
//     while not ready.
// STRUCTURE
//   - Shared package reg_pkg: NUM_REGS=13, REG_CMP=4'h9, REG_SP=4'hA, REG_SF=4'hB,
//     REG_PC=4'hC, REG_DISCARD=4'hF, and the ID_W/DATA_W defaults.
//   - One sub-module: rr_priority_picker (N_REQ request mask + rr_ptr -> one-hot
//     grant + index), purely combinational.
//   - This block holds the output register, rr_ptr, lock/owner, and the bad-id check.
// TESTING
//   1. reset_n=0 with all req_valid=1 -> req_ready=0000, wr_en=0, wr_id=4'hF, wr_value=0.
//   2. Only req1 valid, id=4'h3, value=8'h5A -> ready=0010 same cycle; next cycle
//      wr_en=1, wr_id=3, wr_value=5A; following cycle wr_en=0.
//   3. All four valid for 5 cycles, lock=0 -> grant order 0,1,2,3,0; wr_en=1 from
//      cycle 2 onward.
//   4. req2 sends id=A (lock=1) then id=C (lock=0) while req0 and req3 are valid ->
//      grants 2,2,3,0; writes A,C presented back-to-back.
//   5. req0 id=4'hE, value=8'hFF -> ready=1; next cycle wr_en=0, wr_id=F,
//      err_bad_id=1 for one cycle only.
//   6. Accept id=5 in cycle N, assert reset_n=0 mid-cycle N+1 -> wr_en drops
//      asynchronously and no write to reg 5 is presented after release.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared register-file constants and the arbiter's lock-state encoding.
package reg_pkg;

  localparam int unsigned NUM_REGS   = 13;
  localparam int unsigned ID_W_DEF   = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [3:0] REG_CMP     = 4'h9;
  localparam logic [3:0] REG_SP      = 4'hA;
  localparam logic [3:0] REG_SF      = 4'hB;
  localparam logic [3:0] REG_PC      = 4'hC;
  localparam logic [3:0] REG_DISCARD = 4'hF;

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/register_write_arbiter_if.sv
// Requester handshake plus registered write port toward register_block.
interface register_write_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ID_W-1:0]   req_id;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0]        req_lock;
  logic                    wr_en;
  logic [ID_W-1:0]         wr_id;
  logic [DATA_W-1:0]       wr_value;
  logic                    err_bad_id;
  logic [$clog2(N_REQ)-1:0] grant_idx;

  modport master (
    output req_valid, req_id, req_value, req_lock,
    input  req_ready, wr_en, wr_id, wr_value, err_bad_id, grant_idx
  );

  modport slave (
    input  req_valid, req_id, req_value, req_lock,
    output req_ready, wr_en, wr_id, wr_value, err_bad_id, grant_idx
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit after ptr (wrapping), one-hot + index.
module rr_priority_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [31:0] cand;

  // Scan candidates ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr) + 32'(k)) % 32'(N_REQ);
      if (!any && req[cand[PTR_W-1:0]]) begin
        any                     = 1'b1;
        grant[cand[PTR_W-1:0]]  = 1'b1;
        idx                     = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Shares register_block's single write port among N_REQ writeback requesters:
// round-robin grant, optional lock for multi-register sequences, registered output.
module register_write_arbiter
  import reg_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = ID_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  register_write_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  lock_state_t        lock_state, lock_state_next;
  logic [PTR_W-1:0]   owner, owner_next;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;

  logic [N_REQ-1:0]   owner_mask;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   winner;
  logic               any_grant;
  logic               transfer;
  logic               owner_valid;

  logic [ID_W-1:0]    sel_id;
  logic [DATA_W-1:0]  sel_value;
  logic               sel_lock;
  logic               sel_bad;

  // While locked only the owner may compete; otherwise every valid requester.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    owner_valid       = |(bus.req_valid & owner_mask);
    eligible          = (lock_state == LK_HELD) ? (bus.req_valid & owner_mask)
                                                : bus.req_valid;
  end

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (winner),
    .any   (any_grant)
  );

  assign bus.req_ready = reset_n ? grant : '0;
  assign transfer      = reset_n & any_grant;

  // Mux the winning requester's id/value/lock and classify the id.
  always_comb begin
    sel_id    = '0;
    sel_value = '0;
    sel_lock  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_id    = bus.req_id[i*ID_W +: ID_W];
        sel_value = bus.req_value[i*DATA_W +: DATA_W];
        sel_lock  = bus.req_lock[i];
      end
    end
    sel_bad = (sel_id >= ID_W'(NUM_REGS));
  end

  // Lock FSM next state, owner and round-robin pointer.
  always_comb begin
    lock_state_next = lock_state;
    owner_next      = owner;
    rr_ptr_next     = rr_ptr;
    if (transfer) begin
      rr_ptr_next = winner;
      if (sel_lock) begin
        lock_state_next = LK_HELD;
        owner_next      = winner;
      end else begin
        lock_state_next = LK_FREE;
      end
    end else if (lock_state == LK_HELD && !owner_valid) begin
      // Owner walked away: release and resume the search after the owner.
      lock_state_next = LK_FREE;
      rr_ptr_next     = owner;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_state <= LK_FREE;
      owner      <= '0;
      rr_ptr     <= PTR_W'(N_REQ - 1);
    end else begin
      lock_state <= lock_state_next;
      owner      <= owner_next;
      rr_ptr     <= rr_ptr_next;
    end
  end

  // Registered write port; bad ids are swallowed into REG_DISCARD with an error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_en      <= 1'b0;
      bus.wr_id      <= ID_W'(REG_DISCARD);
      bus.wr_value   <= '0;
      bus.err_bad_id <= 1'b0;
      bus.grant_idx  <= '0;
    end else if (transfer) begin
      bus.wr_en      <= !sel_bad;
      bus.wr_id      <= sel_bad ? ID_W'(REG_DISCARD) : sel_id;
      bus.wr_value   <= sel_bad ? '0 : sel_value;
      bus.err_bad_id <= sel_bad;
      bus.grant_idx  <= winner;
    end else begin
      bus.wr_en      <= 1'b0;
      bus.wr_id      <= ID_W'(REG_DISCARD);
      bus.wr_value   <= '0;
      bus.err_bad_id <= 1'b0;
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter (N_REQ=4, ID_W=4, DATA_W=8).
module tb_register_write_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  register_write_arbiter_if #(.N_REQ(4), .ID_W(4), .DATA_W(8)) bus ();

  register_write_arbiter #(.N_REQ(4), .ID_W(4), .DATA_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_req(input int i, input logic v, input logic [3:0] id,
                         input logic [7:0] val, input logic lk);
    bus.req_valid[i]       = v;
    bus.req_id[i*4 +: 4]   = id;
    bus.req_value[i*8 +: 8] = val;
    bus.req_lock[i]        = lk;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_id    = '0;
    bus.req_value = '0;
    bus.req_lock  = '0;
  endtask

  task automatic apply_reset();
    clear_all();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'h1, 8'h11, 1'b0);
    #20;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    checks++; if (bus.wr_id !== 4'hF) begin errors++; $display("FAIL reset_wr_id: got %h expected f", bus.wr_id); end
    checks++; if (bus.wr_value !== 8'h00) begin errors++; $display("FAIL reset_wr_value: got %h expected 00", bus.wr_value); end
    checks++; if (bus.err_bad_id !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_bad_id); end
    checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx: got %0d expected 0", bus.grant_idx); end
    apply_reset();
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 4'h3, 8'h5A, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", bus.req_ready); end
    @(posedge clock); #1;
    clear_all();
    checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b1, 4'h3, 8'h5A}) begin
      errors++; $display("FAIL single_write: got en=%b id=%h val=%h expected en=1 id=3 val=5a", bus.wr_en, bus.wr_id, bus.wr_value); end
    checks++; if (bus.grant_idx !== 2'd1) begin errors++; $display("FAIL single_grant_idx: got %0d expected 1", bus.grant_idx); end
    @(posedge clock); #1;
    checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b0, 4'hF, 8'h00}) begin
      errors++; $display("FAIL single_idle: got en=%b id=%h val=%h expected en=0 id=f val=00", bus.wr_en, bus.wr_id, bus.wr_value); end
  endtask

  // Starts from reset so requester 0 wins first; leaves rr_ptr at 0.
  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_mask;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 1), 8'(8'h10 + i), 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_mask = 4'b0001 << exp_order[c];
      checks++; if (bus.req_ready !== exp_mask) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, bus.req_ready, exp_mask); end
      @(posedge clock); #1;
      if (c == 4) clear_all();
      checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b1, 4'(exp_order[c] + 1), 8'(8'h10 + exp_order[c])}) begin
        errors++; $display("FAIL rr_write[%0d]: got en=%b id=%h val=%h expected requester %0d", c, bus.wr_en, bus.wr_id, bus.wr_value, exp_order[c]); end
      checks++; if (bus.grant_idx !== 2'(exp_order[c])) begin errors++; $display("FAIL rr_grant_idx[%0d]: got %0d expected %0d", c, bus.grant_idx, exp_order[c]); end
    end
    @(posedge clock); #1;
  endtask

  // Relies on rr_ptr=0 from the round-robin test; ends with rr_ptr=0.
  task automatic test_lock();
    set_req(0, 1'b1, 4'h1, 8'h11, 1'b0);
    set_req(3, 1'b1, 4'h2, 8'h33, 1'b0);
    set_req(2, 1'b1, 4'hA, 8'hA2, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready0: got %b expected 0100", bus.req_ready); end
    @(posedge clock); #1;
    checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b1, 4'hA, 8'hA2}) begin
      errors++; $display("FAIL lock_write_sp: got en=%b id=%h val=%h expected en=1 id=a val=a2", bus.wr_en, bus.wr_id, bus.wr_value); end
    set_req(2, 1'b1, 4'hC, 8'hC2, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready1: got %b expected 0100", bus.req_ready); end
    @(posedge clock); #1;
    checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b1, 4'hC, 8'hC2}) begin
      errors++; $display("FAIL lock_write_pc: got en=%b id=%h val=%h expected en=1 id=c val=c2", bus.wr_en, bus.wr_id, bus.wr_value); end
    set_req(2, 1'b0, 4'h0, 8'h00, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL lock_ready2: got %b expected 1000", bus.req_ready); end
    @(posedge clock); #1;
    checks++; if (bus.wr_id !== 4'h2) begin errors++; $display("FAIL lock_write_r3: got %h expected 2", bus.wr_id); end
    set_req(3, 1'b0, 4'h0, 8'h00, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL lock_ready3: got %b expected 0001", bus.req_ready); end
    @(posedge clock); #1;
    checks++; if (bus.wr_id !== 4'h1) begin errors++; $display("FAIL lock_write_r0: got %h expected 1", bus.wr_id); end
    clear_all();
    @(posedge clock); #1;
  endtask

  // Owner drops valid while locked: nobody served that cycle, then search resumes after owner.
  task automatic test_lock_drop();
    set_req(0, 1'b1, 4'h4, 8'h40, 1'b0);
    set_req(1, 1'b1, 4'h5, 8'h51, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL drop_ready0: got %b expected 0010", bus.req_ready); end
    @(posedge clock); #1;
    set_req(1, 1'b0, 4'h0, 8'h00, 1'b0);
    set_req(2, 1'b1, 4'h6, 8'h62, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL drop_ready1: got %b expected 0000", bus.req_ready); end
    @(posedge clock); #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL drop_idle: got wr_en=%b expected 0", bus.wr_en); end
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL drop_ready2: got %b expected 0100", bus.req_ready); end
    @(posedge clock); #1;
    clear_all();
    checks++; if (bus.wr_id !== 4'h6) begin errors++; $display("FAIL drop_write: got %h expected 6", bus.wr_id); end
    @(posedge clock); #1;
  endtask

  task automatic test_bad_id();
    set_req(0, 1'b1, 4'hE, 8'hFF, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bad_ready: got %b expected 0001", bus.req_ready); end
    @(posedge clock); #1;
    clear_all();
    checks++; if ({bus.wr_en, bus.wr_id, bus.err_bad_id} !== {1'b0, 4'hF, 1'b1}) begin
      errors++; $display("FAIL bad_present: got en=%b id=%h err=%b expected en=0 id=f err=1", bus.wr_en, bus.wr_id, bus.err_bad_id); end
    @(posedge clock); #1;
    checks++; if (bus.err_bad_id !== 1'b0) begin errors++; $display("FAIL bad_pulse: got err=%b expected 0", bus.err_bad_id); end
  endtask

  task automatic test_back_to_back();
    set_req(1, 1'b1, 4'h7, 8'h01, 1'b0);
    @(posedge clock); #1;
    set_req(1, 1'b1, 4'h7, 8'h02, 1'b0);
    checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b1, 4'h7, 8'h01}) begin
      errors++; $display("FAIL b2b_first: got en=%b id=%h val=%h expected en=1 id=7 val=01", bus.wr_en, bus.wr_id, bus.wr_value); end
    @(posedge clock); #1;
    clear_all();
    checks++; if ({bus.wr_en, bus.wr_id, bus.wr_value} !== {1'b1, 4'h7, 8'h02}) begin
      errors++; $display("FAIL b2b_second: got en=%b id=%h val=%h expected en=1 id=7 val=02", bus.wr_en, bus.wr_id, bus.wr_value); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 4'h5, 8'h55, 1'b1);
    @(posedge clock); #1;
    clear_all();
    checks++; if ({bus.wr_en, bus.wr_id} !== {1'b1, 4'h5}) begin
      errors++; $display("FAIL mid_accept: got en=%b id=%h expected en=1 id=5", bus.wr_en, bus.wr_id); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({bus.wr_en, bus.wr_id} !== {1'b0, 4'hF}) begin
      errors++; $display("FAIL mid_async_drop: got en=%b id=%h expected en=0 id=f", bus.wr_en, bus.wr_id); end
    @(posedge clock); #3 reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL mid_no_replay: got wr_en=%b expected 0", bus.wr_en); end
    set_req(1, 1'b1, 4'h2, 8'h22, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_lock_cleared: got %b expected 0010", bus.req_ready); end
    @(posedge clock); #1;
    clear_all();
    checks++; if ({bus.wr_en, bus.wr_id} !== {1'b1, 4'h2}) begin
      errors++; $display("FAIL mid_after_write: got en=%b id=%h expected en=1 id=2", bus.wr_en, bus.wr_id); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    clear_all();
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_bad_id();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
